// File: rtl/seq_div8by4.sv
// Multi-cycle restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero short-circuits to an all-ones result with o_div0 set.
module seq_div8by4 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_dividend,
  input  logic [3:0] i_divisor,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_div0,
  output logic [7:0] o_quotient,
  output logic [3:0] o_remainder
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     r_state;
  logic [4:0] r_rem;
  logic [7:0] r_q;
  logic [2:0] r_cnt;
  logic [3:0] r_divisor;
  logic       r_busy, r_done, r_div0;
  logic [7:0] r_quot;
  logic [3:0] r_remo;

  logic [4:0] w_t;
  logic [5:0] w_sum;
  logic       w_ge;
  logic [4:0] w_rem_nxt;
  logic [7:0] w_q_nxt;

  // Subtract as T + ~divisor + 1 over 5 bits; the carry-out is the T >= divisor flag.
  assign w_t       = {r_rem[3:0], r_q[7]};
  assign w_sum     = {1'b0, w_t} + {1'b0, 1'b1, ~r_divisor} + 6'd1;
  assign w_ge      = w_sum[5];
  assign w_rem_nxt = w_ge ? w_sum[4:0] : w_t;
  assign w_q_nxt   = {r_q[6:0], w_ge};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_div0    <= 1'b0;
      r_quot    <= '0;
      r_remo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_divisor == 4'd0) begin
              r_quot  <= 8'hFF;
              r_remo  <= 4'hF;
              r_div0  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_divisor <= i_divisor;
              r_rem     <= '0;
              r_q       <= i_dividend;
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 3'd1;
          // Eighth iteration: publish results on the same edge as done rises.
          if (r_cnt == 3'd7) begin
            r_quot  <= w_q_nxt;
            r_remo  <= w_rem_nxt[3:0];
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div0      = r_div0;
  assign o_quotient  = r_quot;
  assign o_remainder = r_remo;

endmodule
